// File: rtl/mips_pkg.sv
// Shared types for the MIPS datapath slice.
// Holds the PC FSM state encoding and the word type.
package mips_pkg;
   typedef enum logic [1:0] {BOOT, RUN, PEND} pc_state_t;
   typedef logic [31:0] word_t;
   localparam word_t PC_INC = 32'd4;
endpackage

// File: rtl/pc_next_sel.sv
// Next-PC target formation and priority selection.
// Pure combinational: jump > branch > pending > pc+4.
module pc_next_sel
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] shifted_imm,
   input  logic [25:0] instr_index,
   input  logic        jump,
   input  logic        branch_taken,
   input  logic        pending_valid,
   input  logic [31:0] pending_target,
   output logic [31:0] pc_plus4,
   output logic [31:0] pc_branch,
   output logic [31:0] redirect_target,
   output logic [31:0] next_pc
);

   word_t jump_target;

   assign pc_plus4    = pc + PC_INC;
   assign pc_branch   = pc_plus4 + shifted_imm;
   assign jump_target = {pc_plus4[31:28], instr_index, 2'b00};

   assign redirect_target = jump ? jump_target : pc_branch;

   // Overlapping selects, so an ordered chain rather than a unique case.
   always_comb begin
      next_pc = pc_plus4;
      if (jump)
         next_pc = jump_target;
      else if (branch_taken)
         next_pc = pc_branch;
      else if (pending_valid)
         next_pc = pending_target;
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM and redirect buffering for the MIPS fetch path.
// Optional stall counter output enabled by PC_STALL_CNT_EN.
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter int          WIDTH    = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             imem_ready,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] shifted_imm,
   input  logic             jump,
   input  logic [25:0]      instr_index,
   output logic             fetch_valid,
   output logic [WIDTH-1:0] pc,
`ifdef PC_STALL_CNT_EN
   output logic [31:0]      stall_cycles,
`endif
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] pc_branch
);

   pc_state_t state;
   logic      pending_valid;
   word_t     pending_target;
   word_t     redirect_target;
   word_t     next_pc;
   logic      advance;

   assign advance = fetch_valid & en & imem_ready;

   pc_next_sel u_sel (
      .pc              (pc),
      .shifted_imm     (shifted_imm),
      .instr_index     (instr_index),
      .jump            (jump),
      .branch_taken    (branch_taken),
      .pending_valid   (pending_valid),
      .pending_target  (pending_target),
      .pc_plus4        (pc_plus4),
      .pc_branch       (pc_branch),
      .redirect_target (redirect_target),
      .next_pc         (next_pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= BOOT;
         pc             <= RESET_PC;
         fetch_valid    <= 1'b0;
         pending_valid  <= 1'b0;
         pending_target <= '0;
      end else begin
         unique case (state)
            BOOT: begin
               state       <= RUN;
               fetch_valid <= 1'b1;
            end
            RUN, PEND: begin
               if (advance) begin
                  pc            <= next_pc;
                  pending_valid <= 1'b0;
                  state         <= RUN;
               end else if (jump | branch_taken) begin
                  // Last redirect seen during a stall wins.
                  pending_target <= redirect_target;
                  pending_valid  <= 1'b1;
                  state          <= PEND;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

`ifdef PC_STALL_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cycles <= '0;
      else if (fetch_valid && !advance && stall_cycles != 32'hFFFF_FFFF)
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed table, corner
// sequences and randomized traffic against a behavioural model.
module tb_pc_fetch_unit;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        imem_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] shifted_imm = '0;
   logic [25:0] instr_index = '0;
   logic        fetch_valid;
   logic [31:0] pc, pc_plus4, pc_branch;
`ifdef PC_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   pc_fetch_unit dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .imem_ready   (imem_ready),
      .branch_taken (branch_taken),
      .shifted_imm  (shifted_imm),
      .jump         (jump),
      .instr_index  (instr_index),
      .fetch_valid  (fetch_valid),
      .pc           (pc),
`ifdef PC_STALL_CNT_EN
      .stall_cycles (stall_cycles),
`endif
      .pc_plus4     (pc_plus4),
      .pc_branch    (pc_branch)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: PC value, fetch-valid flag, redirect queue.
   word_t m_pc;
   bit    m_fv;
   word_t pq[$];
   word_t m_cnt;

   task automatic chk(input string name, input word_t act, input word_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc  = 32'h0;
      m_fv  = 1'b0;
      m_cnt = 32'h0;
      pq.delete();
   endtask

   task automatic model_check();
      word_t lowbits;
      lowbits = {30'd0, pc[1:0]};
      if (shifted_imm[1:0] != 2'b00)
         $error("bench drove unaligned shifted_imm");
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv});
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("pc_branch", pc_branch, m_pc + 32'd4 + shifted_imm);
      chk("pc_align", lowbits, 32'd0);
`ifdef PC_STALL_CNT_EN
      chk("stall_cycles", stall_cycles, m_cnt);
`endif
   endtask

   task automatic model_edge();
      word_t p4, pb, jt;
      bit adv;
      if (!m_fv) begin
         m_fv = 1'b1;
         return;
      end
      adv = en && imem_ready;
      p4  = m_pc + 32'd4;
      pb  = p4 + shifted_imm;
      jt  = {p4[31:28], instr_index, 2'b00};
      if (adv) begin
         if (jump)                m_pc = jt;
         else if (branch_taken)   m_pc = pb;
         else if (pq.size() != 0) m_pc = pq[0];
         else                     m_pc = p4;
         pq.delete();
      end else begin
         if (jump || branch_taken) begin
            pq.delete();
            pq.push_back(jump ? jt : pb);
         end
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
   endtask

   task automatic drive(input bit e, input bit r, input bit j, input bit b,
                        input logic [25:0] idx, input word_t imm);
      en           = e;
      imem_ready   = r;
      jump         = j;
      branch_taken = b;
      instr_index  = idx;
      shifted_imm  = imm;
      #1;
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic step(input bit e, input bit r, input bit j, input bit b,
                       input logic [25:0] idx, input word_t imm);
      drive(e, r, j, b, idx, imm);
      model_check();
      finish_cycle();
   endtask

   typedef struct {
      bit          en, rdy, j, b;
      logic [25:0] idx;
      word_t       imm;
      bit          fv;
      word_t       pc;
      bit          cpb;
      word_t       pcb;
   } vec_t;

   vec_t tbl[14];
   word_t c0;

   initial begin
      tbl[0]  = '{1,1,0,0,26'h0,       32'h0,        0, 32'h0,        0, 32'h0};
      tbl[1]  = '{1,1,0,0,26'h0,       32'h0,        1, 32'h0,        0, 32'h0};
      tbl[2]  = '{1,1,0,0,26'h0,       32'h0,        1, 32'h4,        0, 32'h0};
      tbl[3]  = '{1,1,0,0,26'h0,       32'h0,        1, 32'h8,        0, 32'h0};
      tbl[4]  = '{1,1,1,0,26'h0100004, 32'h0,        1, 32'hC,        0, 32'h0};
      tbl[5]  = '{1,1,0,1,26'h0,       32'hFFFFFFF0, 1, 32'h00400010, 1, 32'h00400004};
      tbl[6]  = '{1,1,1,0,26'h0100004, 32'h0,        1, 32'h00400004, 0, 32'h0};
      tbl[7]  = '{1,1,1,1,26'h0100000, 32'hFFFFFFF0, 1, 32'h00400010, 1, 32'h00400004};
      tbl[8]  = '{1,1,0,1,26'h0,       32'hFFBFFFF8, 1, 32'h00400000, 1, 32'hFFFFFFFC};
      tbl[9]  = '{1,1,0,0,26'h0,       32'h0,        1, 32'hFFFFFFFC, 1, 32'h0};
      tbl[10] = '{0,1,0,0,26'h0,       32'h0,        1, 32'h0,        0, 32'h0};
      tbl[11] = '{0,1,0,0,26'h0,       32'h0,        1, 32'h0,        0, 32'h0};
      tbl[12] = '{1,1,0,0,26'h0,       32'h0,        1, 32'h0,        0, 32'h0};
      tbl[13] = '{1,1,0,0,26'h0,       32'h0,        1, 32'h4,        0, 32'h0};

      model_reset();
      #1;
      chk("reset_pc", pc, 32'h0);
      chk("reset_fv", {31'd0, fetch_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].en, tbl[i].rdy, tbl[i].j, tbl[i].b, tbl[i].idx, tbl[i].imm);
         chk($sformatf("tbl%0d_fv", i), {31'd0, fetch_valid}, {31'd0, tbl[i].fv});
         chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
         if (tbl[i].cpb)
            chk($sformatf("tbl%0d_pcb", i), pc_branch, tbl[i].pcb);
         model_check();
         finish_cycle();
      end

      // Stall with a branch in the first stall cycle, then release.
`ifdef PC_STALL_CNT_EN
      c0 = stall_cycles;
`else
      c0 = 32'h0;
`endif
      step(1, 0, 0, 1, 26'h0, 32'h34);
      chk("stall_pc1", pc, 32'h8);
      step(1, 0, 0, 0, 26'h0, 32'h0);
      chk("stall_pc2", pc, 32'h8);
      step(1, 0, 0, 0, 26'h0, 32'h0);
      chk("stall_pc3", pc, 32'h8);
      step(1, 1, 0, 0, 26'h0, 32'h0);
      drive(1, 1, 0, 0, 26'h0, 32'h0);
      chk("pend_target", pc, 32'h40);
`ifdef PC_STALL_CNT_EN
      chk("stall_count", stall_cycles - c0, 32'd3);
`endif
      model_check();
      finish_cycle();

      // Build PEND toward 0x80, then reset asynchronously between edges.
      step(1, 0, 0, 1, 26'h0, 32'h38);
      drive(1, 0, 0, 0, 26'h0, 32'h0);
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      chk("async_rst_pc", pc, 32'h0);
      chk("async_rst_fv", {31'd0, fetch_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step(1, 1, 0, 0, 26'h0, 32'h0);
      drive(1, 1, 0, 0, 26'h0, 32'h0);
      chk("post_rst_pc", pc, 32'h0);
      model_check();
      finish_cycle();
      drive(1, 1, 0, 0, 26'h0, 32'h0);
      chk("no_stale_pend", pc, 32'h4);
      model_check();
      finish_cycle();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 7) != 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 5) == 0,
              26'($urandom),
              $urandom & 32'hFFFF_FFFC);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage of the MIPS datapath. Sits directly downstream of sl2 and consumes its word-aligned branch offset.
- Holds the PC register and forms PC+4, the branch target and the jump target.
- Selects the next PC and advances it only when instruction memory accepts the fetch.
- Stalls, and redirects that arrive while stalled, are buffered so no control-flow change is lost.

Parameters:
WIDTH, 32, datapath width in bits; only 32 is supported.
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  pipeline enable; 0 freezes the PC
imem_ready  input  1  instruction memory accepts the fetch at pc this cycle
branch_taken  input  1  branch resolved taken (pcsrc)
shifted_imm  input  32  sign-extended immediate shifted left by 2, from sl2
jump  input  1  j/jal in flight
instr_index  input  26  instruction bits [25:0]
fetch_valid  output  1  pc holds a valid fetch request
pc  output  32  current PC
pc_plus4  output  32  pc + 4, combinational
pc_branch  output  32  pc_plus4 + shifted_imm, combinational

Behaviour:
- Reset (async, active-high) values:
  - pc = RESET_PC
  - fetch_valid = 0
  - state = BOOT
  - pending_valid = 0
  - pending_target = 0
- Arithmetic: all sums are modulo 2^32 with wrap-around and no flag. Example: 0xFFFFFFFC + 4 = 0x00000000.
- jump_target = {pc_plus4[31:28], instr_index, 2'b00}.
- State machine:
  - BOOT: fetch_valid = 0. Unconditionally goes to RUN on the next clock; en and redirects are ignored.
  - RUN: fetch_valid = 1, no redirect pending.
  - PEND: fetch_valid = 1, a redirect target is held in pending_target.
- advance = fetch_valid & en & imem_ready.
- On advance, pc loads the first match in this priority:
  1. jump -> jump_target
  2. branch_taken -> pc_branch
  3. pending_valid -> pending_target
  4. otherwise -> pc_plus4
- On advance, pending is cleared and the state goes to RUN.
- Not advancing in RUN/PEND with jump or branch_taken asserted:
  - pending_target is latched with the jump target, or the branch target if jump is 0.
  - pending_valid is set and the state goes to PEND.
  - A later redirect during the same stall overwrites the pending target (last wins).
- Not advancing with no redirect: pc, state and pending all hold.
- Latency: pc updates on the first rising edge where advance = 1. There are no bubbles in steady state: one PC per cycle while en and imem_ready are both 1.
- Simultaneous jump and branch_taken: jump wins.
- Reset mid-stall or mid-PEND: pending is discarded, pc returns to RESET_PC, the state returns to BOOT.
- Invariant: pc[1:0] is always 2'b00. shifted_imm[1:0] must be 2'b00; the bench asserts both.

Optional Feature:
- Macro PC_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles (32 bits), reset to 0.
  - Increments every cycle where fetch_valid = 1 and advance = 0.
  - Saturates at 0xFFFFFFFF.
  - Counting is unaffected by redirects.
- Undefined: the port and the counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - typedef enum logic [1:0] pc_state_t {BOOT, RUN, PEND}
  - localparam PC_INC = 32'd4
  - typedef logic [31:0] word_t
- One sub-module, pc_next_sel: combinational target formation plus the priority mux. The parent keeps the registers, the FSM and the counter.

Test Plan:
1. Reset then en = 1, imem_ready = 1 -> cycle 0 fetch_valid = 0 with pc = 0x0. pc then steps 0x0, 0x4, 0x8, 0xC on successive edges.
2. pc = 0x00400010, branch_taken = 1, shifted_imm = 0xFFFFFFF0 -> pc_branch = 0x00400004, next pc = 0x00400004. Same pc with jump = 1 and instr_index = 0x0100000 -> next pc = 0x00400000, jump beating branch.
3. imem_ready = 0 for 3 cycles, branch pulse in stall cycle 1 with target 0x00000040, then imem_ready = 1 and no redirect inputs -> pc held over the stall, PEND entered, next pc = 0x00000040. With PC_STALL_CNT_EN, stall_cycles = 3.
4. pc = 0xFFFFFFFC, advance with no redirect -> pc_plus4 = 0x00000000, next pc = 0x00000000.
5. Assert reset asynchronously mid-PEND (between edges) -> pc = RESET_PC and fetch_valid = 0 immediately. The first fetch after release is at RESET_PC, and the pending target is never used.
6. en = 0 with imem_ready = 1 for 2 cycles, no redirect -> pc held and state stays RUN. Next pc = pc + 4 after en returns to 1.
